wb_trace_buffer: RTL and testbench

- Consumer for the pipeline's writeback debug stream: debug_reg_write_wb, debug_rd_addr_wb, debug_result_w.
- Timestamps each committed register write and buffers it in a FWFT FIFO.
- Drains the FIFO over a valid/ready interface to a testbench scoreboard or a trace port.
- Maintains a shadow architectural register file, readable combinationally, for debug and lockstep checking.

---
 rtl/trace_pkg.sv | 16 +
 rtl/trace_fifo.sv | 63 ++++++
 rtl/wb_trace_buffer.sv | 102 ++++++++++
 tb/tb_wb_trace_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and default sizes for the writeback trace buffer.
// An entry holds the capture timestamp, the destination register and the written value.
package trace_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int REG_ADDR_WIDTH    = 5;
    localparam int TRACE_DEPTH       = 16;
    localparam int TRACE_CYCLE_WIDTH = 32;

    typedef struct packed {
        logic [TRACE_CYCLE_WIDTH-1:0] cycle;
        logic [REG_ADDR_WIDTH-1:0]    rd_addr;
        logic [DATA_WIDTH-1:0]        data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through synchronous FIFO.
// Power-of-two depth: the pointers wrap naturally and a separate counter tracks occupancy.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = 1;
    localparam logic [LEVEL_W-1:0] LEVEL_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage is not reset; the occupancy counter decides what is valid, so stale slots are never seen.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        rdata = '0;
        if (!empty) rdata = mem[rd_ptr];
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Timestamps committed writeback register writes into a FWFT trace FIFO with overflow accounting,
// and keeps a shadow architectural register file for debug and lockstep comparison.
module wb_trace_buffer #(
    parameter int DEPTH          = trace_pkg::TRACE_DEPTH,
    parameter int DATA_WIDTH     = trace_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = trace_pkg::REG_ADDR_WIDTH,
    parameter int CYCLE_WIDTH    = trace_pkg::TRACE_CYCLE_WIDTH,
    parameter int DROP_X0        = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           trace_en_i,
    input  logic                           wb_reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0]      wb_rd_addr_i,
    input  logic [DATA_WIDTH-1:0]          wb_result_i,
    output logic                           trace_valid_o,
    input  logic                           trace_ready_i,
    output logic [CYCLE_WIDTH-1:0]         trace_cycle_o,
    output logic [REG_ADDR_WIDTH-1:0]      trace_rd_addr_o,
    output logic [DATA_WIDTH-1:0]          trace_data_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o,
    output logic                           overflow_o,
    output logic [CNT_WIDTH-1:0]           drop_count_o,
    input  logic                           clear_overflow_i,
    input  logic [REG_ADDR_WIDTH-1:0]      shadow_addr_i,
    output logic [DATA_WIDTH-1:0]          shadow_data_o
);

    localparam int ENTRY_W  = CYCLE_WIDTH + REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
    localparam logic DROP_ZERO = (DROP_X0 != 0);
    localparam logic [CYCLE_WIDTH-1:0] CYCLE_ONE = 1;
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = 1;

    logic [CYCLE_WIDTH-1:0] cycle_q;
    logic [ENTRY_W-1:0]     wr_entry;
    logic [ENTRY_W-1:0]     rd_entry;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   ev;
    logic                   do_pop;
    logic                   do_push;
    logic                   drop;
    logic [DATA_WIDTH-1:0]  shadow_q [NUM_REGS];

    assign ev       = wb_reg_write_i & trace_en_i & ~(DROP_ZERO & (wb_rd_addr_i == '0));
    assign do_pop   = trace_valid_o & trace_ready_i;
    assign do_push  = ev & (~fifo_full | do_pop);
    assign drop     = ev & fifo_full & ~do_pop;
    assign wr_entry = {cycle_q, wb_rd_addr_i, wb_result_i};

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign trace_valid_o = ~fifo_empty;
    assign {trace_cycle_o, trace_rd_addr_o, trace_data_o} = rd_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_q + CYCLE_ONE;
    end

    // A drop coinciding with a clear restarts the count at one rather than losing the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (clear_overflow_i)   drop_count_o <= CNT_ONE;
            else if (~&drop_count_o) drop_count_o <= drop_count_o + CNT_ONE;
        end else if (clear_overflow_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end
    end

    // The shadow file is architectural state, so unlike FIFO storage it must come out of reset as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else if (wb_reg_write_i && (wb_rd_addr_i != '0)) begin
            shadow_q[wb_rd_addr_i] <= wb_result_i;
        end
    end

    assign shadow_data_o = (shadow_addr_i == '0) ? '0 : shadow_q[shadow_addr_i];

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: stimulus queues expected trace entries, a monitor
// compares them and the status outputs against a queue-based reference model.
module tb_wb_trace_buffer;
    import trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        trace_en, we, ready, clr;
    logic [4:0]  rd, saddr;
    logic [31:0] data;

    logic        valid_a;
    logic [31:0] cycle_a, data_a, shadow_a;
    logic [4:0]  rd_a;
    logic [4:0]  level_a;
    logic        ovf_a;
    logic [15:0] cnt_a;

    logic        trace_en_b, ready_b;
    logic        valid_b;
    logic [31:0] cycle_b, data_b, shadow_b;
    logic [4:0]  rd_b;
    logic [4:0]  level_b;
    logic        ovf_b;
    logic [15:0] cnt_b;

    always #5 clk = ~clk;

    wb_trace_buffer dut (
        .clk(clk), .rst(rst), .trace_en_i(trace_en), .wb_reg_write_i(we),
        .wb_rd_addr_i(rd), .wb_result_i(data), .trace_valid_o(valid_a),
        .trace_ready_i(ready), .trace_cycle_o(cycle_a), .trace_rd_addr_o(rd_a),
        .trace_data_o(data_a), .level_o(level_a), .overflow_o(ovf_a),
        .drop_count_o(cnt_a), .clear_overflow_i(clr), .shadow_addr_i(saddr),
        .shadow_data_o(shadow_a)
    );

    wb_trace_buffer #(.DROP_X0(0)) dut_b (
        .clk(clk), .rst(rst), .trace_en_i(trace_en_b), .wb_reg_write_i(we),
        .wb_rd_addr_i(rd), .wb_result_i(data), .trace_valid_o(valid_b),
        .trace_ready_i(ready_b), .trace_cycle_o(cycle_b), .trace_rd_addr_o(rd_b),
        .trace_data_o(data_b), .level_o(level_b), .overflow_o(ovf_b),
        .drop_count_o(cnt_b), .clear_overflow_i(1'b0), .shadow_addr_i(saddr),
        .shadow_data_o(shadow_b)
    );

    // Reference model: state after the most recent posedge, advanced by drive().
    trace_entry_t exp_q[$];
    int          m_level, m_cnt;
    bit          m_ovf;
    logic [31:0] m_cycle;
    logic [31:0] m_shadow [32];
    // Snapshot of the model as seen by the monitor during the current cycle.
    int          cur_level, cur_cnt;
    bit          cur_ovf;
    logic [31:0] cur_shadow;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level = 0; m_cnt = 0; m_ovf = 1'b0; m_cycle = '0;
        for (int i = 0; i < 32; i++) m_shadow[i] = '0;
        cur_level = 0; cur_cnt = 0; cur_ovf = 1'b0; cur_shadow = '0;
    endtask

    // One clock of stimulus; called at posedge+2, returns at the next posedge+2.
    task automatic drive(input bit w, input logic [4:0] a, input logic [31:0] d,
                         input bit en, input bit r, input bit c);
        bit pop, ev, drop;
        trace_entry_t e;
        cur_level = m_level; cur_ovf = m_ovf; cur_cnt = m_cnt;
        we = w; rd = a; data = d; trace_en = en; ready = r; clr = c;
        saddr = 5'($urandom_range(0, 31));
        cur_shadow = (saddr == 0) ? 32'h0 : m_shadow[saddr];
        pop  = r && (m_level > 0);
        ev   = w && en && (a != 0);
        drop = 1'b0;
        if (ev) begin
            if (m_level == DEPTH && !pop) drop = 1'b1;
            else begin
                e.cycle = m_cycle; e.rd_addr = a; e.data = d;
                exp_q.push_back(e);
                m_level++;
            end
        end
        if (pop) m_level--;
        if (drop) begin
            m_ovf = 1'b1;
            m_cnt = c ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
        end else if (c) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (w && a != 0) m_shadow[a] = d;
        m_cycle++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'h0, 1'b1, r, 1'b0);
    endtask

    // Monitor: compares status every cycle and the head entry whenever valid is presented.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("valid", valid_a, cur_level > 0);
                check("level", level_a, cur_level);
                check("overflow", ovf_a, cur_ovf);
                check("drop_count", cnt_a, cur_cnt);
                check("shadow_read", shadow_a, cur_shadow);
                if (valid_a) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL head: valid with no expected entry at %0t", $time);
                    end else begin
                        check("head_cycle", cycle_a, exp_q[0].cycle);
                        check("head_rd", rd_a, exp_q[0].rd_addr);
                        check("head_data", data_a, exp_q[0].data);
                        if (ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] cap_cycle;
        logic [4:0]  keep_addr;
        rst = 1'b1; we = 1'b0; rd = '0; data = '0; trace_en = 1'b0; ready = 1'b0;
        clr = 1'b0; saddr = 5'd5; trace_en_b = 1'b0; ready_b = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        check("rst_valid", valid_a, 0);
        check("rst_level", level_a, 0);
        check("rst_overflow", ovf_a, 0);
        check("rst_drop_count", cnt_a, 0);
        check("rst_cycle_out", cycle_a, 0);
        check("rst_rd_out", rd_a, 0);
        check("rst_data_out", data_a, 0);
        check("rst_shadow", shadow_a, 0);
        rst = 1'b0;

        // Two writes at cycles 3 and 4 drain in order one cycle after capture.
        idle(3, 1'b1);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
        #1;
        check("first_cycle", cycle_a, 3);
        check("first_data", data_a, 32'hDEADBEEF);
        drive(1'b1, 5'd6, 32'h1, 1'b1, 1'b1, 1'b0);
        #1;
        check("second_cycle", cycle_a, 4);
        check("second_rd", rd_a, 6);
        idle(3, 1'b1);
        check("drained_level", level_a, 0);

        // x0 write: dropped by the default instance, traced by the DROP_X0=0 instance.
        cap_cycle = m_cycle;
        trace_en_b = 1'b1;
        drive(1'b1, 5'd0, 32'hA5A50001, 1'b1, 1'b0, 1'b0);
        trace_en_b = 1'b0;
        #1;
        check("x0_level_a", level_a, 0);
        check("x0_valid_b", valid_b, 1);
        check("x0_level_b", level_b, 1);
        check("x0_rd_b", rd_b, 0);
        check("x0_data_b", data_b, 32'hA5A50001);
        check("x0_cycle_b", cycle_b, cap_cycle);
        keep_addr = saddr;
        saddr = 5'd0;
        #1;
        check("x0_shadow_a", shadow_a, 0);
        check("x0_shadow_b", shadow_b, 0);
        saddr = keep_addr;
        ready_b = 1'b1;
        idle(1, 1'b0);
        ready_b = 1'b0;
        check("x0_level_b_drained", level_b, 0);

        // Twenty events into a stalled FIFO: sixteen kept, four dropped.
        for (int i = 0; i < 20; i++)
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 1'b0, 1'b0);
        #1;
        check("full_level", level_a, 16);
        check("full_overflow", ovf_a, 1);
        check("full_drop_count", cnt_a, 4);

        // Full FIFO with event and pop together: no drop, level held.
        drive(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0);
        #1;
        check("push_pop_level", level_a, 16);
        check("push_pop_count", cnt_a, 4);

        // Drop with clear in the same cycle, then clear alone.
        drive(1'b1, 5'd8, 32'h12345678, 1'b1, 1'b0, 1'b1);
        #1;
        check("drop_clear_ovf", ovf_a, 1);
        check("drop_clear_cnt", cnt_a, 1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
        #1;
        check("clear_ovf", ovf_a, 0);
        check("clear_cnt", cnt_a, 0);

        idle(15, 1'b1);
        #1;
        check("last_level", level_a, 1);
        check("last_entry", data_a, 32'hCAFEF00D);
        idle(3, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 31) == 0);
        idle(20, 1'b1);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Reset with seven entries queued.
        drive(1'b1, 5'd5, 32'h5555AAAA, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 1'b0, 1'b0);
        #1;
        check("pre_reset_level", level_a, 7);
        rst = 1'b1;
        saddr = 5'd5;
        #1;
        check("async_rst_valid", valid_a, 0);
        check("async_rst_level", level_a, 0);
        check("async_rst_shadow", shadow_a, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b0);
        #1;
        check("restart_cycle", cycle_a, 0);
        idle(3, 1'b1);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
